// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, select
// encodings and the control word carried from decode into EX.
package ctrl_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_CMP  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_OUT  = 4'd6;
   localparam logic [3:0] OP_MOV  = 4'd7;
   localparam logic [3:0] OP_LDI  = 4'd8;
   localparam logic [3:0] OP_JMP  = 4'd9;
   localparam logic [3:0] OP_BR   = 4'd10;
   localparam logic [3:0] OP_CALL = 4'd11;
   localparam logic [3:0] OP_RET  = 4'd12;
   localparam logic [3:0] OP_LD   = 4'd13;
   localparam logic [3:0] OP_ST   = 4'd14;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_IMM = 2'd2;
   localparam logic [1:0] WB_OTH = 2'd3;

   localparam logic [1:0] PC_LR  = 2'd0;
   localparam logic [1:0] PC_INC = 2'd1;
   localparam logic [1:0] PC_TGT = 2'd2;

   typedef struct packed {
      logic       valid;
      logic       mux2;
      logic       dmwe;
      logic       nfen;
      logic       zfen;
      logic       regwe;
      logic       lrwe;
      logic [1:0] wbsel;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder: produces the control word for the
// instruction in ID and which source registers it actually reads.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic [OPW-1:0] op,
   output ctrl_t          ctrl,
   output logic [OPW-1:0] opalu,
   output logic [3:0]     opn,
   output logic           rd_rs1,
   output logic           rd_rs2
);

   // Opcodes beyond the defined range collapse to NOP before decoding
   if (OPW > 4) begin : g_wide
      assign opn = (|op[OPW-1:4]) ? OP_NOP : op[3:0];
   end else begin : g_narrow
      assign opn = 4'(op);
   end

   assign opalu = OPW'(opn);

   // Opcode-to-control table; common values first, exceptions per opcode
   always_comb begin
      ctrl       = CTRL_BUBBLE;
      ctrl.valid = 1'b1;
      ctrl.mux2  = (opn != OP_MOV);
      ctrl.dmwe  = (opn == OP_ST);
      ctrl.lrwe  = (opn == OP_CALL);
      ctrl.nfen  = (opn >= OP_ADD) && (opn <= OP_CMP);
      ctrl.zfen  = (opn >= OP_ADD) && (opn <= OP_OR);
      ctrl.regwe = 1'b1;
      ctrl.wbsel = WB_OTH;
      rd_rs1     = 1'b1;
      rd_rs2     = 1'b0;
      case (opn)
         OP_NOP, OP_JMP, OP_RET: begin
            ctrl.regwe = 1'b0;
            rd_rs1     = 1'b0;
         end
         OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR: begin
            ctrl.wbsel = WB_ALU;
            rd_rs2     = 1'b1;
         end
         OP_OUT, OP_BR, OP_CALL: begin
            ctrl.regwe = 1'b0;
         end
         OP_LDI: begin
            ctrl.wbsel = WB_IMM;
         end
         OP_LD: begin
            ctrl.wbsel = WB_MEM;
         end
         OP_ST: begin
            ctrl.regwe = 1'b0;
            rd_rs2     = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes in ID, carries control through EX and WB,
// owns the N/Z flags, resolves transfers in ID and handles hazards.
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int OPW        = 4,
   parameter int RAW        = 2,
   parameter int FLAG_STALL = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           id_valid,
   input  logic [OPW-1:0] id_op,
   input  logic           id_brx,
   input  logic [RAW-1:0] id_rs1,
   input  logic [RAW-1:0] id_rs2,
   input  logic [RAW-1:0] id_rd,
   input  logic           ex_nf,
   input  logic           ex_zf,
   output logic           id_ready,
   output logic           pc_en,
   output logic [1:0]     pc_sel,
   output logic           flush,
   output logic           ex_valid,
   output logic [OPW-1:0] ex_opalu,
   output logic           ex_mux2,
   output logic           ex_dmwe,
   output logic           ex_nfen,
   output logic           ex_zfen,
   output logic           wb_valid,
   output logic [1:0]     wb_sel,
   output logic           wb_regwe,
   output logic [RAW-1:0] wb_rd,
   output logic           wb_lrwe,
   output logic           flag_n,
   output logic           flag_z
);

   typedef enum logic {S_RUN, S_KILL} state_t;

   state_t         state;
   state_t         state_nxt;
   ctrl_t          dec_ctrl;
   ctrl_t          ex_q;
   ctrl_t          ex_d;
   logic [OPW-1:0] dec_opalu;
   logic [OPW-1:0] ex_opalu_d;
   logic [3:0]     dec_opn;
   logic           dec_rs1;
   logic           dec_rs2;
   logic [RAW-1:0] ex_rd;
   logic [RAW-1:0] ex_rd_d;
   logic           load_use;
   logic           flag_haz;
   logic           cur_n;
   logic           cur_z;
   logic           cond;

   ctrl_decode #(.OPW(OPW)) u_decode (
      .op     (id_op),
      .ctrl   (dec_ctrl),
      .opalu  (dec_opalu),
      .opn    (dec_opn),
      .rd_rs1 (dec_rs1),
      .rd_rs2 (dec_rs2)
   );

   assign ex_valid = ex_q.valid;
   assign ex_mux2  = ex_q.mux2;
   assign ex_dmwe  = ex_q.dmwe;
   assign ex_nfen  = ex_q.nfen;
   assign ex_zfen  = ex_q.zfen;
   assign pc_en    = id_ready;

   // Branch condition source and hazard detection against the EX stage
   always_comb begin
      cur_n = flag_n;
      cur_z = flag_z;
      if (FLAG_STALL == 0) begin
         if (ex_q.valid && ex_q.nfen) cur_n = ex_nf;
         if (ex_q.valid && ex_q.zfen) cur_z = ex_zf;
      end
      cond     = id_brx ? cur_n : cur_z;
      load_use = id_valid && ex_q.valid && (ex_opalu == OPW'(OP_LD)) &&
                 ((dec_rs1 && (id_rs1 == ex_rd)) || (dec_rs2 && (id_rs2 == ex_rd)));
      flag_haz = (FLAG_STALL != 0) && id_valid && (dec_opn == OP_BR) &&
                 ex_q.valid && (ex_q.nfen || ex_q.zfen);
   end

   // Issue control: kill after a taken transfer, then stalls, then issue
   always_comb begin
      state_nxt  = S_RUN;
      id_ready   = 1'b1;
      pc_sel     = PC_INC;
      flush      = 1'b0;
      ex_d       = CTRL_BUBBLE;
      ex_opalu_d = '0;
      ex_rd_d    = '0;
      if (state == S_RUN) begin
         if (load_use || flag_haz) begin
            id_ready = 1'b0;
         end else if (id_valid) begin
            ex_d       = dec_ctrl;
            ex_opalu_d = dec_opalu;
            ex_rd_d    = id_rd;
            case (dec_opn)
               OP_JMP, OP_CALL: begin
                  pc_sel    = PC_TGT;
                  flush     = 1'b1;
                  state_nxt = S_KILL;
               end
               OP_RET: begin
                  pc_sel    = PC_LR;
                  flush     = 1'b1;
                  state_nxt = S_KILL;
               end
               OP_BR: begin
                  if (cond) begin
                     pc_sel    = PC_TGT;
                     flush     = 1'b1;
                     state_nxt = S_KILL;
                  end else begin
                     ex_d       = CTRL_BUBBLE;
                     ex_opalu_d = '0;
                     ex_rd_d    = '0;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Kill state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_RUN;
      else     state <= state_nxt;
   end

   // EX and WB pipeline registers; WB always follows EX
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q     <= CTRL_BUBBLE;
         ex_opalu <= '0;
         ex_rd    <= '0;
         wb_valid <= 1'b0;
         wb_sel   <= 2'd0;
         wb_regwe <= 1'b0;
         wb_rd    <= '0;
         wb_lrwe  <= 1'b0;
      end else begin
         ex_q     <= ex_d;
         ex_opalu <= ex_opalu_d;
         ex_rd    <= ex_rd_d;
         wb_valid <= ex_q.valid;
         wb_sel   <= ex_q.wbsel;
         wb_regwe <= ex_q.regwe;
         wb_rd    <= ex_rd;
         wb_lrwe  <= ex_q.lrwe;
      end
   end

   // Architectural flags take the live ALU flags of an enabled EX op
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_n <= 1'b0;
         flag_z <= 1'b0;
      end else begin
         if (ex_q.valid && ex_q.nfen) flag_n <= ex_nf;
         if (ex_q.valid && ex_q.zfen) flag_z <= ex_zf;
      end
   end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: one instance with flag stalling, one with
// live flag bypass, both fed the same instruction stream.
module tb_ctrl_pipe;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [3:0] id_op;
   logic       id_brx;
   logic [1:0] id_rs1, id_rs2, id_rd;
   logic       ex_nf, ex_zf;

   logic       id_ready, pc_en, flush, ex_valid, ex_mux2, ex_dmwe, ex_nfen, ex_zfen;
   logic [1:0] pc_sel, wb_sel, wb_rd;
   logic [3:0] ex_opalu;
   logic       wb_valid, wb_regwe, wb_lrwe, flag_n, flag_z;

   logic       id_ready_b, pc_en_b, flush_b, ex_valid_b, ex_mux2_b, ex_dmwe_b, ex_nfen_b, ex_zfen_b;
   logic [1:0] pc_sel_b, wb_sel_b, wb_rd_b;
   logic [3:0] ex_opalu_b;
   logic       wb_valid_b, wb_regwe_b, wb_lrwe_b, flag_n_b, flag_z_b;

   int total = 0;
   int bad   = 0;

   ctrl_pipe #(.OPW(4), .RAW(2), .FLAG_STALL(1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_brx(id_brx),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_nf(ex_nf), .ex_zf(ex_zf),
      .id_ready(id_ready), .pc_en(pc_en), .pc_sel(pc_sel), .flush(flush),
      .ex_valid(ex_valid), .ex_opalu(ex_opalu), .ex_mux2(ex_mux2), .ex_dmwe(ex_dmwe),
      .ex_nfen(ex_nfen), .ex_zfen(ex_zfen), .wb_valid(wb_valid), .wb_sel(wb_sel),
      .wb_regwe(wb_regwe), .wb_rd(wb_rd), .wb_lrwe(wb_lrwe), .flag_n(flag_n), .flag_z(flag_z)
   );

   ctrl_pipe #(.OPW(4), .RAW(2), .FLAG_STALL(0)) dut_byp (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_brx(id_brx),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_nf(ex_nf), .ex_zf(ex_zf),
      .id_ready(id_ready_b), .pc_en(pc_en_b), .pc_sel(pc_sel_b), .flush(flush_b),
      .ex_valid(ex_valid_b), .ex_opalu(ex_opalu_b), .ex_mux2(ex_mux2_b), .ex_dmwe(ex_dmwe_b),
      .ex_nfen(ex_nfen_b), .ex_zfen(ex_zfen_b), .wb_valid(wb_valid_b), .wb_sel(wb_sel_b),
      .wb_regwe(wb_regwe_b), .wb_rd(wb_rd_b), .wb_lrwe(wb_lrwe_b), .flag_n(flag_n_b), .flag_z(flag_z_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one ID instruction (or an empty slot when v is 0)
   task automatic drive(input logic v, input logic [3:0] op, input logic brx,
                        input logic [1:0] rs1, input logic [1:0] rs2, input logic [1:0] rd);
      id_valid = v;
      id_op    = op;
      id_brx   = brx;
      id_rs1   = rs1;
      id_rs2   = rs2;
      id_rd    = rd;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0);
      ex_nf = 1'b0;
      ex_zf = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_ex_valid: got %0b want 0", ex_valid); end
      total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_wb_valid: got %0b want 0", wb_valid); end
      total++; if (ex_opalu !== 4'd0) begin bad++; $display("[TB] FAIL rst_ex_opalu: got %0d want 0", ex_opalu); end
      total++; if ({flag_n, flag_z} !== 2'b00) begin bad++; $display("[TB] FAIL rst_flags: got %b want 00", {flag_n, flag_z}); end
      total++; if (id_ready !== 1'b1 || pc_sel !== 2'd1) begin bad++; $display("[TB] FAIL rst_idle: got ready=%0b sel=%0d want 1/1", id_ready, pc_sel); end
      rst = 1'b0;
   endtask

   task automatic test_alu;
      @(negedge clk);
      drive(1'b1, 4'd1, 1'b0, 2'd0, 2'd1, 2'd2);
      ex_nf = 1'b0;
      ex_zf = 1'b1;
      #1;
      total++; if (id_ready !== 1'b1 || flush !== 1'b0) begin bad++; $display("[TB] FAIL alu_issue: got ready=%0b flush=%0b want 1/0", id_ready, flush); end
      @(negedge clk);
      drive(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0);
      #1;
      total++; if (ex_valid !== 1'b1 || ex_opalu !== 4'd1) begin bad++; $display("[TB] FAIL alu_ex: got v=%0b op=%0d want 1/1", ex_valid, ex_opalu); end
      total++; if ({ex_nfen, ex_zfen, ex_mux2, ex_dmwe} !== 4'b1110) begin bad++; $display("[TB] FAIL alu_ex_en: got %b want 1110", {ex_nfen, ex_zfen, ex_mux2, ex_dmwe}); end
      @(negedge clk);
      #1;
      total++; if (wb_valid !== 1'b1 || wb_sel !== 2'd0 || wb_regwe !== 1'b1) begin bad++; $display("[TB] FAIL alu_wb: got v=%0b sel=%0d we=%0b want 1/0/1", wb_valid, wb_sel, wb_regwe); end
      total++; if (wb_rd !== 2'd2) begin bad++; $display("[TB] FAIL alu_wb_rd: got %0d want 2", wb_rd); end
      total++; if ({flag_n, flag_z} !== 2'b01) begin bad++; $display("[TB] FAIL alu_flags: got %b want 01", {flag_n, flag_z}); end
   endtask

   task automatic test_load_use;
      @(negedge clk);
      drive(1'b1, 4'd13, 1'b0, 2'd3, 2'd0, 2'd1);
      #1;
      total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL ld_issue: got %0b want 1", id_ready); end
      @(negedge clk);
      drive(1'b1, 4'd3, 1'b0, 2'd1, 2'd0, 2'd0);
      #1;
      total++; if (ex_opalu !== 4'd13 || ex_valid !== 1'b1) begin bad++; $display("[TB] FAIL ld_ex: got op=%0d v=%0b want 13/1", ex_opalu, ex_valid); end
      total++; if (id_ready !== 1'b0 || pc_en !== 1'b0) begin bad++; $display("[TB] FAIL ld_stall: got ready=%0b pc_en=%0b want 0/0", id_ready, pc_en); end
      @(negedge clk);
      #1;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL ld_bubble: got %0b want 0", ex_valid); end
      total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL ld_stall_len: got %0b want 1", id_ready); end
      total++; if (wb_sel !== 2'd1 || wb_regwe !== 1'b1 || wb_rd !== 2'd1) begin bad++; $display("[TB] FAIL ld_wb: got sel=%0d we=%0b rd=%0d want 1/1/1", wb_sel, wb_regwe, wb_rd); end
      @(negedge clk);
      drive(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0);
      #1;
      total++; if (ex_valid !== 1'b1 || ex_opalu !== 4'd3) begin bad++; $display("[TB] FAIL ld_reissue: got v=%0b op=%0d want 1/3", ex_valid, ex_opalu); end
      total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL ld_wb_bubble: got %0b want 0", wb_valid); end
   endtask

   task automatic test_flag_stall;
      @(negedge clk);
      drive(1'b1, 4'd2, 1'b0, 2'd0, 2'd0, 2'd3);
      ex_nf = 1'b1;
      ex_zf = 1'b0;
      #1;
      total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL fs_issue: got %0b want 1", id_ready); end
      @(negedge clk);
      drive(1'b1, 4'd10, 1'b1, 2'd0, 2'd0, 2'd0);
      #1;
      total++; if (id_ready !== 1'b0 || pc_en !== 1'b0) begin bad++; $display("[TB] FAIL fs_stall: got ready=%0b pc_en=%0b want 0/0", id_ready, pc_en); end
      total++; if (id_ready_b !== 1'b1 || pc_sel_b !== 2'd2 || flush_b !== 1'b1) begin bad++; $display("[TB] FAIL byp_taken: got ready=%0b sel=%0d flush=%0b want 1/2/1", id_ready_b, pc_sel_b, flush_b); end
      @(negedge clk);
      #1;
      total++; if (id_ready !== 1'b1 || pc_sel !== 2'd2 || flush !== 1'b1) begin bad++; $display("[TB] FAIL fs_taken: got ready=%0b sel=%0d flush=%0b want 1/2/1", id_ready, pc_sel, flush); end
      total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL fs_bubble: got %0b want 0", ex_valid); end
      total++; if (pc_sel_b !== 2'd1 || flush_b !== 1'b0) begin bad++; $display("[TB] FAIL byp_kill: got sel=%0d flush=%0b want 1/0", pc_sel_b, flush_b); end
      @(negedge clk);
      drive(1'b1, 4'd1, 1'b0, 2'd0, 2'd0, 2'd1);
      #1;
      total++; if (id_ready !== 1'b1 || pc_sel !== 2'd1 || flush !== 1'b0) begin bad++; $display("[TB] FAIL fs_kill: got ready=%0b sel=%0d flush=%0b want 1/1/0", id_ready, pc_sel, flush); end
      total++; if (ex_valid !== 1'b1 || ex_opalu !== 4'd10) begin bad++; $display("[TB] FAIL fs_br_ex: got v=%0b op=%0d want 1/10", ex_valid, ex_opalu); end
      @(negedge clk);
      drive(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0);
      ex_nf = 1'b0;
      ex_zf = 1'b1;
      #1;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL fs_killed: got %0b want 0", ex_valid); end
      total++; if ({flag_n, flag_z} !== 2'b10) begin bad++; $display("[TB] FAIL fs_flags: got %b want 10", {flag_n, flag_z}); end
   endtask

   task automatic test_bypass_not_taken;
      @(negedge clk);
      drive(1'b1, 4'd2, 1'b0, 2'd0, 2'd0, 2'd3);
      @(negedge clk);
      drive(1'b1, 4'd10, 1'b0, 2'd0, 2'd0, 2'd0);
      ex_nf = 1'b1;
      ex_zf = 1'b0;
      #1;
      total++; if (flag_z_b !== 1'b1) begin bad++; $display("[TB] FAIL byp_arch_z: got %0b want 1", flag_z_b); end
      total++; if (id_ready_b !== 1'b1 || pc_sel_b !== 2'd1 || flush_b !== 1'b0) begin bad++; $display("[TB] FAIL byp_nt: got ready=%0b sel=%0d flush=%0b want 1/1/0", id_ready_b, pc_sel_b, flush_b); end
      total++; if (id_ready !== 1'b0) begin bad++; $display("[TB] FAIL nt_stall: got %0b want 0", id_ready); end
      @(negedge clk);
      #1;
      total++; if (id_ready !== 1'b1 || pc_sel !== 2'd1 || flush !== 1'b0) begin bad++; $display("[TB] FAIL nt_resolve: got ready=%0b sel=%0d flush=%0b want 1/1/0", id_ready, pc_sel, flush); end
      total++; if (flag_n !== 1'b1) begin bad++; $display("[TB] FAIL nt_flag_n: got %0b want 1", flag_n); end
      @(negedge clk);
      drive(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0);
      #1;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL nt_bubble: got %0b want 0", ex_valid); end
   endtask

   task automatic test_call_ret;
      @(negedge clk);
      drive(1'b1, 4'd11, 1'b0, 2'd0, 2'd0, 2'd0);
      #1;
      total++; if (pc_sel !== 2'd2 || flush !== 1'b1) begin bad++; $display("[TB] FAIL call_sel: got sel=%0d flush=%0b want 2/1", pc_sel, flush); end
      @(negedge clk);
      drive(1'b1, 4'd12, 1'b0, 2'd0, 2'd0, 2'd0);
      #1;
      total++; if (pc_sel !== 2'd1 || flush !== 1'b0 || id_ready !== 1'b1) begin bad++; $display("[TB] FAIL call_kill: got sel=%0d flush=%0b ready=%0b want 1/0/1", pc_sel, flush, id_ready); end
      @(negedge clk);
      #1;
      total++; if (pc_sel !== 2'd0 || flush !== 1'b1) begin bad++; $display("[TB] FAIL ret_sel: got sel=%0d flush=%0b want 0/1", pc_sel, flush); end
      total++; if (wb_valid !== 1'b1 || wb_lrwe !== 1'b1 || wb_regwe !== 1'b0) begin bad++; $display("[TB] FAIL call_wb: got v=%0b lr=%0b we=%0b want 1/1/0", wb_valid, wb_lrwe, wb_regwe); end
      @(negedge clk);
      drive(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0);
      #1;
      total++; if (ex_valid !== 1'b1 || ex_opalu !== 4'd12) begin bad++; $display("[TB] FAIL ret_ex: got v=%0b op=%0d want 1/12", ex_valid, ex_opalu); end
      @(negedge clk);
      #1;
      total++; if (wb_valid !== 1'b1 || wb_lrwe !== 1'b0 || wb_regwe !== 1'b0) begin bad++; $display("[TB] FAIL ret_wb: got v=%0b lr=%0b we=%0b want 1/0/0", wb_valid, wb_lrwe, wb_regwe); end
   endtask

   task automatic test_reset_mid_stall;
      @(negedge clk);
      drive(1'b1, 4'd13, 1'b0, 2'd0, 2'd0, 2'd2);
      @(negedge clk);
      drive(1'b1, 4'd4, 1'b0, 2'd2, 2'd0, 2'd1);
      #1;
      total++; if (id_ready !== 1'b0) begin bad++; $display("[TB] FAIL rs_stall: got %0b want 0", id_ready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0);
      #1;
      total++; if (ex_valid !== 1'b0 || wb_valid !== 1'b0 || wb_regwe !== 1'b0) begin bad++; $display("[TB] FAIL rs_pipe: got ex=%0b wb=%0b we=%0b want 0/0/0", ex_valid, wb_valid, wb_regwe); end
      total++; if ({flag_n, flag_z} !== 2'b00) begin bad++; $display("[TB] FAIL rs_flags: got %b want 00", {flag_n, flag_z}); end
      @(negedge clk);
      drive(1'b1, 4'd9, 1'b0, 2'd0, 2'd0, 2'd0);
      rst = 1'b1;
      #1;
      total++; if (pc_sel !== 2'd2) begin bad++; $display("[TB] FAIL rs_jmp_sel: got %0d want 2", pc_sel); end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 4'd1, 1'b0, 2'd0, 2'd0, 2'd3);
      #1;
      total++; if (pc_sel !== 2'd1 || flush !== 1'b0 || id_ready !== 1'b1) begin bad++; $display("[TB] FAIL rs_fresh: got sel=%0d flush=%0b ready=%0b want 1/0/1", pc_sel, flush, id_ready); end
      @(negedge clk);
      drive(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0);
      #1;
      total++; if (ex_valid !== 1'b1 || ex_opalu !== 4'd1) begin bad++; $display("[TB] FAIL rs_no_kill: got v=%0b op=%0d want 1/1", ex_valid, ex_opalu); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_use();
      test_flag_stall();
      test_bypass_not_taken();
      test_call_ret();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
